// File: rtl/btn_led_counter_ctrl_if.sv
// Button/LED bundle between the board I/O (master) and the counter controller (slave).
// up_state/dn_state expose each debounce FSM's encoding for observation.
interface btn_led_counter_ctrl_if #(
  parameter int LED_bit = 8
);
  logic               btn_up;
  logic               btn_dn;
  logic               clr;
  logic [LED_bit-1:0] led;
  logic               step;
  logic               wrap;
  logic               up_held;
  logic               dn_held;
  logic [2:0]         up_state;
  logic [2:0]         dn_state;

  modport master (
    output btn_up, btn_dn, clr,
    input  led, step, wrap, up_held, dn_held, up_state, dn_state
  );

  modport slave (
    input  btn_up, btn_dn, clr,
    output led, step, wrap, up_held, dn_held, up_state, dn_state
  );
endinterface

// File: rtl/btn_led_counter_ctrl.sv
// Up/down LED counter driven by two raw pushbuttons:
// a 2-flop synchronizer, a debounce/auto-repeat FSM per button, and an arbitrated counter update.
module btn_led_counter_ctrl #(
  parameter int LED_bit       = 8,
  parameter int DEB_CYCLES    = 1000000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 20000000
) (
  input logic                   clk,
  input logic                   rst_n,
  btn_led_counter_ctrl_if.slave bus
);

  localparam int MAX_A  = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_CHK = 3'd1,
    PRESSED   = 3'd2,
    REPEAT    = 3'd3,
    REL_CHK   = 3'd4
  } btn_state_e;

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q;
  logic [1:0]       s_q;
  btn_state_e       state_q [2];
  btn_state_e       state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       evt;

  logic [LED_bit-1:0] led_q, led_d;
  logic               step_q, step_d;
  logic               wrap_q, wrap_d;

  assign btn_raw = {bus.btn_dn, bus.btn_up};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      s_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      s_q     <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // evt is a Mealy output so the counter sees it the cycle the threshold is reached.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      evt[i]     = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (s_q[i]) begin
            state_d[i] = PRESS_CHK;
            cnt_d[i]   = '0;
          end
        end
        PRESS_CHK: begin
          if (!s_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            evt[i]     = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s_q[i]) begin
            state_d[i] = REL_CHK;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == HOLD_LAST) begin
            state_d[i] = REPEAT;
            cnt_d[i]   = '0;
            evt[i]     = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        REPEAT: begin
          if (!s_q[i]) begin
            state_d[i] = REL_CHK;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == REP_LAST) begin
            cnt_d[i] = '0;
            evt[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        REL_CHK: begin
          // A bounce back to 1 restarts the hold timer without a new event.
          if (s_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    led_d  = led_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (bus.clr) begin
      led_d = '0;
    end else if (evt[0] && evt[1]) begin
      led_d = led_q;
    end else if (evt[0]) begin
      led_d  = led_q + 1'b1;
      step_d = 1'b1;
      wrap_d = &led_q;
    end else if (evt[1]) begin
      led_d  = led_q - 1'b1;
      step_d = 1'b1;
      wrap_d = (led_q == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q  <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.led      = led_q;
  assign bus.step     = step_q;
  assign bus.wrap     = wrap_q;
  assign bus.up_held  = (state_q[0] == PRESSED) || (state_q[0] == REPEAT);
  assign bus.dn_held  = (state_q[1] == PRESSED) || (state_q[1] == REPEAT);
  assign bus.up_state = state_q[0];
  assign bus.dn_state = state_q[1];

endmodule

// File: doc/btn_led_counter_ctrl.md
Name: btn_led_counter_ctrl

Overview:
- Clocked controller that sequences the LED binary counter from two raw pushbuttons (up, down).
- Replaces the "button-as-clock" counting scheme with a synchronous design:
  - synchronizer
  - debounce FSM per button
  - hold-to-auto-repeat
  - up/down arbitration
- Sits between the board buttons and the LED bank on the Zedboard labs; the counter register is owned here.

Parameters:
- LED_bit, 8, width of the LED counter.
- DEB_CYCLES, 1000000, clocks a synchronized level must stay stable to be accepted (10 ms at 100 MHz); minimum 2.
- HOLD_CYCLES, 50000000, clocks held in PRESSED before auto-repeat starts; minimum 2.
- REPEAT_CYCLES, 20000000, clocks between auto-repeat steps; minimum 2.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- btn_up, input, 1, raw up button, active-high, asynchronous, bouncy.
- btn_dn, input, 1, raw down button, active-high, asynchronous, bouncy.
- clr, input, 1, synchronous clear of counter, active-high.
- led, output, LED_bit, counter value.
- step, output, 1, one-cycle pulse when led changed due to a button event.
- wrap, output, 1, one-cycle pulse coincident with step when the counter wrapped.
- up_held, output, 1, up FSM in PRESSED or REPEAT.
- dn_held, output, 1, down FSM in PRESSED or REPEAT.

Behaviour:
- Reset (rst_n=0, async):
  - led=0, step=0, wrap=0, up_held=0, dn_held=0.
  - Synchronizer flops=0, FSMs=IDLE, all counters=0.
- Reset mid-press aborts immediately. After release of reset, a still-held button is treated as a new press and goes through the full debounce.
- Synchronizer: 2-flop per button; "s" below denotes the synchronized level.
- Per-button FSM, identical for up and down; one shared-width counter cnt per button:
  - IDLE: s=1 -> PRESS_CHK, cnt=0.
  - PRESS_CHK: s=0 -> IDLE. s=1 and cnt==DEB_CYCLES-1 -> PRESSED, cnt=0, evt=1 for one cycle. Otherwise cnt++.
  - PRESSED: s=0 -> REL_CHK, cnt=0. cnt==HOLD_CYCLES-1 -> REPEAT, cnt=0, evt=1. Otherwise cnt++.
  - REPEAT: s=0 -> REL_CHK, cnt=0. cnt==REPEAT_CYCLES-1 -> cnt=0, evt=1. Otherwise cnt++.
  - REL_CHK: s=1 -> PRESSED, cnt=0, no evt (release bounce; the hold timer restarts). s=0 and cnt==DEB_CYCLES-1 -> IDLE. Otherwise cnt++.
- Timing: if s first reads 1 at edge k and stays 1, evt is high in the cycle after edge k+DEB_CYCLES. led updates at edge k+DEB_CYCLES+1, with step/wrap high in that same cycle.
- A press shorter than DEB_CYCLES produces no event; glitches are ignored.
- Counter update, registered, one cycle after evt. Priority order:
  1. clr=1: led=0, step=0, wrap=0; pending events are dropped.
  2. up_evt and dn_evt both set: no change, step=0.
  3. up_evt only: led=led+1, modulo 2^LED_bit. If old led was all-ones, new led=0 and wrap=1.
  4. dn_evt only: led=led-1. If old led was 0, new led=all-ones and wrap=1.
  5. Otherwise: hold; step=0, wrap=0.
- step and wrap are registered, one-cycle pulses, never high for consecutive cycles unless consecutive events occur.
- up_held/dn_held are combinational decodes of the FSM state: high in PRESSED or REPEAT only (not in REL_CHK).
- The two FSMs are fully independent; holding one button does not block the other.
- Counter widths are sized by clog2 of the largest of the three cycle parameters. Counters never overflow, because every state compares with == and then clears.

Test Plan (LED_bit=8, DEB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3 unless noted):
- Clean press: btn_up=1 for 8 clocks from reset -> exactly one step pulse; led=1; wrap=0; up_held=1 during the press.
- Bounce rejection: btn_up toggles 1,0,1,0 at 1-clock intervals, then stays 1 for 20 clocks -> exactly one press event; led=1. The release, with 2-clock bounces then 0, produces no extra step.
- Auto-repeat: hold btn_up 30 clocks after debounce -> step at debounce, again 10 clocks later, then every 3 clocks; led equals the counted pulses (e.g. 1+1+6=8 steps total is checked against the pulse count).
- Wrap: preload led=255 via up presses, press up -> led=0, wrap=1. Then press down -> led=255, wrap=1.
- Simultaneous: btn_up and btn_dn rise on the same edge -> both evt coincide, led unchanged, step=0. A clr pulse with a pending up_evt -> led=0, step=0.
- Async reset mid-operation: assert rst_n=0 during REPEAT -> all outputs 0 immediately. Release with btn_up still high -> a new step appears only after the full DEB_CYCLES+sync latency.
